// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared funct3 encodings, FSM states and access-size helper
//                for the load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 4'd1;
            F3_H, F3_HU: return 4'd2;
            F3_W, F3_WU: return 4'd4;
            default:     return 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Request/response handshake plus memory port of the LSU.
//  Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] endereco;
    logic [63:0] write_data;
    logic [63:0] read_data;

    // Master is the environment: execute stage plus the memory behind the LSU
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, endereco, write_data
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, endereco, write_data
    );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Big-endian load extraction/extension and store byte merge.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] rbuf,
    input  logic [63:0] wdata,
    input  logic [2:0]  funct3,
    output logic [63:0] load_ext,
    output logic [63:0] store_merge
);

    // The addressed byte is the most significant byte of the 8-byte window
    always_comb begin
        load_ext    = '0;
        store_merge = '0;
        case (funct3[1:0])
            2'b00: begin
                load_ext    = funct3[2] ? {56'd0, rbuf[63:56]} : {{56{rbuf[63]}}, rbuf[63:56]};
                store_merge = {wdata[7:0], rbuf[55:0]};
            end
            2'b01: begin
                load_ext    = funct3[2] ? {48'd0, rbuf[63:48]} : {{48{rbuf[63]}}, rbuf[63:48]};
                store_merge = {wdata[15:0], rbuf[47:0]};
            end
            2'b10: begin
                load_ext    = funct3[2] ? {32'd0, rbuf[63:32]} : {{32{rbuf[63]}}, rbuf[63:32]};
                store_merge = {wdata[31:0], rbuf[31:0]};
            end
            default: begin
                load_ext    = rbuf;
                store_merge = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding sized load/store unit with read-modify-
//                write for sub-doubleword stores and alignment/range checks.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES   = 2048,
    parameter int CHECK_ALIGN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rbuf_q, rbuf_d;
    logic        err_q, err_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic [3:0]  req_size;
    logic        req_illegal, req_misalign, req_range, req_err;
    logic [63:0] load_ext, store_merge;

    // The whole 8-byte window must fit, so the range limit is MEM_BYTES-8
    always_comb begin
        req_size     = size_bytes(bus.req_funct3);
        req_illegal  = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
        req_misalign = (CHECK_ALIGN != 0) &&
                       ((bus.req_addr & (64'(req_size) - 64'd1)) != 64'd0);
        req_range    = bus.req_addr > 64'(MEM_BYTES - 8);
        req_err      = req_illegal | req_misalign | req_range;
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    err_d    = req_err;
                    if (req_err)
                        state_d = RESP;
                    else if (bus.req_write && (bus.req_funct3 == F3_D))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                rbuf_d  = bus.read_data;
                state_d = write_q ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            default: if (bus.resp_ready) state_d = IDLE;
        endcase
        // Control outputs are registered against the next state
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        mem_read_d   = (state_d == READ);
        mem_write_d  = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    lsu_align u_align (
        .rbuf        (rbuf_q),
        .wdata       (wdata_q),
        .funct3      (funct3_q),
        .load_ext    (load_ext),
        .store_merge (store_merge)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_valid_q && err_q;
    assign bus.resp_rdata = (resp_valid_q && !err_q && !write_q) ? load_ext : '0;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.endereco   = (mem_read_q || mem_write_q) ? addr_q : '0;
    assign bus.write_data = mem_write_q ? store_merge : '0;

endmodule
`default_nettype wire
